// File: rtl/aes_tcdm_responder_pkg.sv
// Shared constants, request/response types and the stall LFSR step for the
// AES TCDM responder.
package aes_tcdm_package;

  localparam logic [31:0] TCDM_POISON = 32'hDEAD_BEEF;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_req_t;

  typedef struct packed {
    logic [31:0] r_data;
    logic        r_valid;
  } tcdm_rsp_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/aes_tcdm_rr_arbiter.sv
// Round-robin single-grant arbiter; the pointer holds the port where the
// next search starts and only moves when a grant is issued.
module aes_tcdm_rr_arbiter #(
  parameter int NB_PORTS = 4,
  parameter int IDX_W    = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [NB_PORTS-1:0] req_i,
  input  logic                en_i,
  output logic [NB_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                valid_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;
  int               c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    c     = 0;
    for (int i = 0; i < NB_PORTS; i++) begin
      c    = (int'(ptr_q) + i) % NB_PORTS;
      cand = IDX_W'(c);
      if (en_i && !found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (found) gnt_o[idx_o] = 1'b1;
    valid_o = found;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clear)      ptr_d = '0;
    else if (found) ptr_d = IDX_W'((int'(idx_o) + 1) % NB_PORTS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/aes_tcdm_responder.sv
// Memory-side TCDM slave: round-robin arbitration of NB_PORTS initiators onto
// one word memory, plus a backdoor port and optional LFSR grant stalls.
module aes_tcdm_responder
  import aes_tcdm_package::*;
#(
  parameter int unsigned NB_PORTS  = 4,
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h1C01_0000,
  parameter bit          STALL_EN  = 1'b0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic [NB_PORTS-1:0]          tcdm_req_i,
  output logic [NB_PORTS-1:0]          tcdm_gnt_o,
  input  logic [NB_PORTS*32-1:0]       tcdm_add_i,
  input  logic [NB_PORTS-1:0]          tcdm_wen_i,
  input  logic [NB_PORTS*4-1:0]        tcdm_be_i,
  input  logic [NB_PORTS*32-1:0]       tcdm_data_i,
  output logic [NB_PORTS*32-1:0]       tcdm_r_data_o,
  output logic [NB_PORTS-1:0]          tcdm_r_valid_o,
  input  logic                         bd_en_i,
  input  logic                         bd_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_widx_i,
  input  logic [31:0]                  bd_wdata_i,
  output logic [31:0]                  bd_rdata_o,
  output logic                         err_o,
  output logic [31:0]                  err_addr_o
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int IDX_W = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

  logic [31:0]         mem [MEM_WORDS];
  logic [15:0]         lfsr_q, lfsr_d;
  logic [NB_PORTS-1:0] r_valid_q, r_valid_d, r_valid_out;
  logic [31:0]         r_data_q, r_data_d;
  logic [31:0]         bd_rdata_q, bd_rdata_d;
  logic                err_q, err_d;
  logic [31:0]         err_addr_q, err_addr_d;
  logic                arb_en, granted, in_range, mem_we;
  logic [IDX_W-1:0]    gnt_idx;
  tcdm_req_t           sel;
  logic [31:0]         offset;
  logic [AW-1:0]       widx;

  // Grants are withheld in reset, in the clear cycle, during backdoor use and on stall cycles.
  assign arb_en = reset_n && !clear && !bd_en_i && !(STALL_EN && lfsr_q[0]);

  aes_tcdm_rr_arbiter #(
    .NB_PORTS (NB_PORTS),
    .IDX_W    (IDX_W)
  ) i_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .req_i   (tcdm_req_i),
    .en_i    (arb_en),
    .gnt_o   (tcdm_gnt_o),
    .idx_o   (gnt_idx),
    .valid_o (granted)
  );

  always_comb begin
    sel = '0;
    for (int p = 0; p < NB_PORTS; p++) begin
      if (IDX_W'(p) == gnt_idx) begin
        sel.add  = tcdm_add_i[p*32 +: 32];
        sel.wen  = tcdm_wen_i[p];
        sel.be   = tcdm_be_i[p*4 +: 4];
        sel.data = tcdm_data_i[p*32 +: 32];
      end
    end
  end

  assign offset   = sel.add - BASE_ADDR;
  assign in_range = (sel.add >= BASE_ADDR) && ((offset >> 2) < 32'(MEM_WORDS));
  assign widx     = offset[AW+1:2];

  always_comb begin
    lfsr_d     = clear ? LFSR_SEED : lfsr_next(lfsr_q);
    mem_we     = granted && !sel.wen && in_range;
    r_valid_d  = clear ? '0 : tcdm_gnt_o;
    r_data_d   = '0;
    if (granted && sel.wen) r_data_d = in_range ? mem[widx] : TCDM_POISON;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (clear) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end else if (granted && !in_range) begin
      err_d = 1'b1;
      if (!err_q) err_addr_d = sel.add;
    end
    bd_rdata_d = (bd_en_i && !bd_we_i) ? mem[bd_widx_i] : bd_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (bd_en_i && bd_we_i) begin
      mem[bd_widx_i] <= bd_wdata_i;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel.be[b]) mem[widx][b*8 +: 8] <= sel.data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q     <= LFSR_SEED;
      r_valid_q  <= '0;
      r_data_q   <= '0;
      bd_rdata_q <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      bd_rdata_q <= bd_rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // A clear drops the response that would otherwise be presented this cycle.
  always_comb begin
    r_valid_out   = clear ? '0 : r_valid_q;
    tcdm_r_data_o = '0;
    for (int p = 0; p < NB_PORTS; p++) begin
      if (r_valid_out[p]) tcdm_r_data_o[p*32 +: 32] = r_data_q;
    end
  end

  assign tcdm_r_valid_o = r_valid_out;
  assign bd_rdata_o     = bd_rdata_q;
  assign err_o          = err_q;
  assign err_addr_o     = err_addr_q;

endmodule

// File: tb/tb_aes_tcdm_responder.sv
// Self-checking bench for aes_tcdm_responder: directed scenarios plus a
// randomized run compared against a behavioural memory/arbitration model.
module tb_aes_tcdm_responder;

  localparam int          NP   = 4;
  localparam int          MW   = 4096;
  localparam logic [31:0] BASE = 32'h1C01_0000;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, clear;
  logic [NP-1:0] req, gnt, wen, rvalid;
  logic [NP*32-1:0] add, wdata, rdata;
  logic [NP*4-1:0]  be;
  logic          bd_en, bd_we;
  logic [11:0]   bd_widx;
  logic [31:0]   bd_wdata, bd_rdata, err_addr;
  logic          err;

  logic          s_reset_n, s_clear;
  logic [NP-1:0] s_req, s_gnt, s_wen, s_rvalid;
  logic [NP*32-1:0] s_add, s_wdata, s_rdata;
  logic [NP*4-1:0]  s_be;
  logic          s_bd_en, s_bd_we;
  logic [7:0]    s_bd_widx;
  logic [31:0]   s_bd_wdata, s_bd_rdata, s_err_addr;
  logic          s_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem_m [16];

  aes_tcdm_responder #(.NB_PORTS(NP), .MEM_WORDS(MW), .BASE_ADDR(BASE), .STALL_EN(1'b0), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be),
    .tcdm_data_i(wdata), .tcdm_r_data_o(rdata), .tcdm_r_valid_o(rvalid),
    .bd_en_i(bd_en), .bd_we_i(bd_we), .bd_widx_i(bd_widx), .bd_wdata_i(bd_wdata), .bd_rdata_o(bd_rdata),
    .err_o(err), .err_addr_o(err_addr));

  aes_tcdm_responder #(.NB_PORTS(NP), .MEM_WORDS(256), .BASE_ADDR(BASE), .STALL_EN(1'b1), .LFSR_SEED(SEED)) dut_stall (
    .clk(clk), .reset_n(s_reset_n), .clear(s_clear),
    .tcdm_req_i(s_req), .tcdm_gnt_o(s_gnt), .tcdm_add_i(s_add), .tcdm_wen_i(s_wen), .tcdm_be_i(s_be),
    .tcdm_data_i(s_wdata), .tcdm_r_data_o(s_rdata), .tcdm_r_valid_o(s_rvalid),
    .bd_en_i(s_bd_en), .bd_we_i(s_bd_we), .bd_widx_i(s_bd_widx), .bd_wdata_i(s_bd_wdata), .bd_rdata_o(s_bd_rdata),
    .err_o(s_err), .err_addr_o(s_err_addr));

  // Reference LFSR built from the tap list (tap t feeds from bit 16-t).
  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    int  taps [4];
    logic fb;
    taps = '{16, 14, 13, 11};
    fb = 1'b0;
    for (int k = 0; k < 4; k++) fb ^= s[16 - taps[k]];
    return {fb, s[15:1]};
  endfunction

  function automatic int rr_pick(input logic [NP-1:0] r, input int ptr);
    for (int k = 0; k < NP; k++) if (r[(ptr + k) % NP]) return (ptr + k) % NP;
    return -1;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < MW);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    req[p] = 1'b1;
    add[p*32 +: 32] = a;
    wen[p] = w;
    be[p*4 +: 4] = b;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic rand_port(input int p);
    int w;
    w = $urandom_range(0, 15);
    if ($urandom_range(0, 15) == 0)
      add[p*32 +: 32] = $urandom_range(0, 1) ? BASE - 32'(4 * $urandom_range(1, 4)) : BASE + 32'h4000 + 32'(4 * w);
    else
      add[p*32 +: 32] = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
    wen[p] = 1'($urandom_range(0, 1));
    be[p*4 +: 4] = 4'($urandom_range(0, 15));
    wdata[p*32 +: 32] = $urandom;
  endtask

  task automatic bd_write(input int idx, input logic [31:0] d);
    bd_en = 1'b1; bd_we = 1'b1; bd_widx = 12'(idx); bd_wdata = d;
    tick();
    bd_en = 1'b0; bd_we = 1'b0;
  endtask

  task automatic bd_read(input int idx, output logic [31:0] d);
    bd_en = 1'b1; bd_we = 1'b0; bd_widx = 12'(idx);
    tick();
    bd_en = 1'b0;
    d = bd_rdata;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_reset_n = 1'b0; clear = 1'b0; s_clear = 1'b0;
    bd_en = 1'b0; bd_we = 1'b0; bd_widx = '0; bd_wdata = '0;
    s_bd_en = 1'b0; s_bd_we = 1'b0; s_bd_widx = '0; s_bd_wdata = '0;
    s_req = '0; s_add = '0; s_wen = '0; s_be = '0; s_wdata = '0;
    req = '0; add = '0; wen = '0; be = '0; wdata = '0;
    for (int p = 0; p < NP; p++) set_port(p, BASE + 32'(4 * p), 1'b1, 4'hF, 32'h0);
    tick(); tick();
    total++; if (gnt !== 4'b0) begin bad++; $display("[TB] FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (rvalid !== 4'b0) begin bad++; $display("[TB] FAIL reset_rvalid got=%b want=0000", rvalid); end
    total++; if (rdata !== '0) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=0", rdata); end
    total++; if (bd_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_bd_rdata got=%h want=0", bd_rdata); end
    total++; if (err !== 1'b0 || err_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_err got=%b/%h want=0/0", err, err_addr); end
    total++; if (s_gnt !== 4'b0 || s_rvalid !== 4'b0) begin bad++; $display("[TB] FAIL reset_stall_dut got=%b/%b want=0/0", s_gnt, s_rvalid); end
    req = '0;
    reset_n = 1'b1; s_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_backdoor_read();
    bd_write(0, 32'h0011_2233);
    set_port(0, BASE, 1'b1, 4'h0, 32'h0);
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL bd_read_gnt got=%b want=0001", gnt); end
    tick();
    req = '0;
    total++; if (rvalid !== 4'b0001) begin bad++; $display("[TB] FAIL bd_read_rvalid got=%b want=0001", rvalid); end
    total++; if (rdata !== {96'h0, 32'h0011_2233}) begin bad++; $display("[TB] FAIL bd_read_rdata got=%h want=%h", rdata, {96'h0, 32'h0011_2233}); end
  endtask

  task automatic test_partial_write();
    logic [31:0] rb;
    bd_write(1, 32'hFFFF_FFFF);
    set_port(1, BASE + 32'h4, 1'b0, 4'b0101, 32'hAABB_CCDD);
    #1;
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL pw_gnt got=%b want=0010", gnt); end
    tick();
    req = '0;
    total++; if (rvalid !== 4'b0010 || rdata !== '0) begin bad++; $display("[TB] FAIL pw_resp got=%b/%h want=0010/0", rvalid, rdata); end
    bd_read(1, rb);
    total++; if (rb !== 32'hFFBB_FFDD) begin bad++; $display("[TB] FAIL pw_readback got=%h want=FFBBFFDD", rb); end
  endtask

  task automatic test_round_robin();
    logic [NP*32-1:0] exp_rd;
    int g, w;
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 8; k++) begin mem_m[k] = $urandom; bd_write(k, mem_m[k]); end
    for (int p = 0; p < NP; p++) begin
      w = $urandom_range(0, 7);
      set_port(p, BASE + 32'(4 * w), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end
    for (int c = 0; c < 8; c++) begin
      #1;
      g = c % NP;
      total++; if (gnt !== 4'(1 << g) || $countones(gnt) != 1) begin bad++; $display("[TB] FAIL rr_gnt cycle=%0d got=%b want=%b", c, gnt, 4'(1 << g)); end
      w = int'((add[g*32 +: 32] - BASE) >> 2);
      exp_rd = '0;
      if (wen[g]) exp_rd[g*32 +: 32] = mem_m[w];
      else mem_m[w] = merge(mem_m[w], wdata[g*32 +: 32], be[g*4 +: 4]);
      tick();
      total++; if (rvalid !== 4'(1 << g) || rdata !== exp_rd) begin bad++; $display("[TB] FAIL rr_resp cycle=%0d got=%b/%h want=%b/%h", c, rvalid, rdata, 4'(1 << g), exp_rd); end
      w = $urandom_range(0, 7);
      set_port(g, BASE + 32'(4 * w), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      #0;
    end
    req = '0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rb;
    set_port(2, 32'h1C00_FFFC, 1'b1, 4'h0, 32'h0);
    #1;
    total++; if (gnt !== 4'b0100) begin bad++; $display("[TB] FAIL oor_gnt got=%b want=0100", gnt); end
    tick();
    req = '0;
    total++; if (rvalid !== 4'b0100 || rdata !== {32'h0, 32'hDEAD_BEEF, 64'h0}) begin bad++; $display("[TB] FAIL oor_poison got=%b/%h want=0100/deadbeef", rvalid, rdata); end
    total++; if (err !== 1'b1 || err_addr !== 32'h1C00_FFFC) begin bad++; $display("[TB] FAIL oor_err got=%b/%h want=1/1c00fffc", err, err_addr); end
    set_port(3, 32'h1C02_0000, 1'b0, 4'hF, 32'h1234_5678);
    #1;
    total++; if (gnt !== 4'b1000) begin bad++; $display("[TB] FAIL oor2_gnt got=%b want=1000", gnt); end
    tick();
    req = '0;
    total++; if (rvalid !== 4'b1000 || err_addr !== 32'h1C00_FFFC) begin bad++; $display("[TB] FAIL oor2_sticky got=%b/%h want=1000/1c00fffc", rvalid, err_addr); end
    bd_read(0, rb);
    total++; if (rb !== mem_m[0]) begin bad++; $display("[TB] FAIL oor_no_write got=%h want=%h", rb, mem_m[0]); end
    clear = 1'b1; tick(); clear = 1'b0;
    total++; if (err !== 1'b0 || err_addr !== 32'h0) begin bad++; $display("[TB] FAIL oor_clear got=%b/%h want=0/0", err, err_addr); end
  endtask

  task automatic test_clear_after_grant();
    set_port(1, BASE, 1'b1, 4'h0, 32'h0);
    #1;
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL cag_gnt got=%b want=0010", gnt); end
    tick();
    clear = 1'b1;
    set_port(1, BASE + 32'h4, 1'b1, 4'h0, 32'h0);
    set_port(2, BASE + 32'h8, 1'b1, 4'h0, 32'h0);
    #1;
    total++; if (rvalid !== 4'b0 || gnt !== 4'b0) begin bad++; $display("[TB] FAIL cag_drop got=%b/%b want=0000/0000", rvalid, gnt); end
    tick();
    clear = 1'b0;
    #1;
    total++; if (rvalid !== 4'b0) begin bad++; $display("[TB] FAIL cag_after got=%b want=0000", rvalid); end
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL cag_ptr got=%b want=0010", gnt); end
    tick();
    req = '0;
    total++; if (rvalid !== 4'b0010 || rdata[63:32] !== mem_m[1]) begin bad++; $display("[TB] FAIL cag_resp got=%b/%h want=0010/%h", rvalid, rdata[63:32], mem_m[1]); end
  endtask

  task automatic test_random();
    int ptr, g, w, bidx;
    logic err_m;
    logic [31:0] erra, bdexp, a, rb;
    logic [NP-1:0] rv, eg, hold;
    logic [NP*32-1:0] rdv, nrd;
    for (int k = 0; k < 16; k++) begin mem_m[k] = $urandom; bd_write(k, mem_m[k]); end
    bd_read(0, rb);
    bdexp = mem_m[0];
    clear = 1'b1; tick(); clear = 1'b0;
    ptr = 0; err_m = 1'b0; erra = '0; rv = '0; rdv = '0; hold = '0;
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < NP; p++) if (!hold[p]) begin req[p] = 1'($urandom_range(0, 1)); rand_port(p); end
      g = $urandom_range(0, 31);
      bd_en = (g < 4); clear = (g == 31);
      bd_we = 1'($urandom_range(0, 1)); bidx = $urandom_range(0, 15); bd_widx = 12'(bidx); bd_wdata = $urandom;
      #1;
      g  = rr_pick(req, ptr);
      eg = (clear || bd_en || g < 0) ? '0 : 4'(1 << g);
      total++; if (gnt !== eg) begin bad++; $display("[TB] FAIL rnd_gnt n=%0d got=%b want=%b", n, gnt, eg); end
      total++; if (rvalid !== (clear ? 4'b0 : rv) || rdata !== (clear ? '0 : rdv)) begin bad++; $display("[TB] FAIL rnd_resp n=%0d got=%b/%h want=%b/%h", n, rvalid, rdata, clear ? 4'b0 : rv, clear ? '0 : rdv); end
      total++; if (err !== err_m || err_addr !== erra || bd_rdata !== bdexp) begin bad++; $display("[TB] FAIL rnd_state n=%0d got=%b/%h/%h want=%b/%h/%h", n, err, err_addr, bd_rdata, err_m, erra, bdexp); end
      nrd = '0;
      if (eg != '0) begin
        a = add[g*32 +: 32];
        w = int'((a - BASE) >> 2);
        if (!addr_ok(a)) begin
          if (wen[g]) nrd[g*32 +: 32] = 32'hDEAD_BEEF;
          if (!err_m) erra = a;
          err_m = 1'b1;
        end else if (wen[g]) nrd[g*32 +: 32] = mem_m[w];
        else mem_m[w] = merge(mem_m[w], wdata[g*32 +: 32], be[g*4 +: 4]);
        ptr = (g + 1) % NP;
      end
      if (bd_en) begin
        if (bd_we) mem_m[bidx] = bd_wdata;
        else bdexp = mem_m[bidx];
      end
      if (clear) begin ptr = 0; err_m = 1'b0; erra = '0; end
      rv = eg; rdv = nrd;
      hold = req & ~eg;
      tick();
    end
    req = '0; bd_en = 1'b0; clear = 1'b0;
  endtask

  task automatic test_stall();
    logic [15:0] lf;
    logic [31:0] sd [6];
    logic pend;
    int i, pulses, cyc;
    s_clear = 1'b1; tick(); s_clear = 1'b0;
    lf = SEED; i = 0; pulses = 0; pend = 1'b0; cyc = 0;
    for (int k = 0; k < 6; k++) sd[k] = $urandom;
    while ((i < 6 || pend) && cyc < 300) begin
      if (i < 6) begin
        s_req[0] = 1'b1; s_add[31:0] = BASE + 32'(4 * i); s_wen[0] = 1'b0; s_be[3:0] = 4'hF; s_wdata[31:0] = sd[i];
      end else s_req[0] = 1'b0;
      #1;
      total++; if (s_gnt !== {3'b0, (i < 6) && !lf[0]}) begin bad++; $display("[TB] FAIL stall_gnt cyc=%0d got=%b want=%b lfsr=%h", cyc, s_gnt, {3'b0, (i < 6) && !lf[0]}, lf); end
      total++; if (s_rvalid !== {3'b0, pend}) begin bad++; $display("[TB] FAIL stall_rvalid cyc=%0d got=%b want=%b", cyc, s_rvalid, {3'b0, pend}); end
      if (s_rvalid[0]) pulses++;
      pend = (i < 6) && !lf[0];
      if (pend) i++;
      lf = ref_lfsr(lf);
      cyc++;
      tick();
    end
    s_req = '0;
    total++; if (cyc >= 300) begin bad++; $display("[TB] FAIL stall_budget served=%0d want=6", i); end
    total++; if (pulses != 6) begin bad++; $display("[TB] FAIL stall_pulses got=%0d want=6", pulses); end
    for (int k = 0; k < 6; k++) begin
      s_bd_en = 1'b1; s_bd_we = 1'b0; s_bd_widx = 8'(k);
      tick();
      s_bd_en = 1'b0;
      total++; if (s_bd_rdata !== sd[k]) begin bad++; $display("[TB] FAIL stall_data idx=%0d got=%h want=%h", k, s_bd_rdata, sd[k]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] rb;
    bd_write(0, 32'hCAFE_F00D);
    bd_read(0, rb);
    total++; if (rb !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL rst_pre_bd got=%h want=cafef00d", rb); end
    set_port(0, BASE - 32'h4, 1'b1, 4'h0, 32'h0);
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_err got=%b want=1", err); end
    for (int p = 0; p < NP; p++) set_port(p, BASE + 32'(4 * p), 1'b1, 4'h0, 32'h0);
    tick();
    total++; if ($countones(rvalid) != 1) begin bad++; $display("[TB] FAIL rst_pre_rvalid got=%b want=onehot", rvalid); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (gnt !== 4'b0 || rvalid !== 4'b0 || rdata !== '0) begin bad++; $display("[TB] FAIL rst_async_port got=%b/%b/%h want=0/0/0", gnt, rvalid, rdata); end
    total++; if (bd_rdata !== 32'h0 || err !== 1'b0 || err_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_async_state got=%h/%b/%h want=0/0/0", bd_rdata, err, err_addr); end
    req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_backdoor_read();
    test_partial_write();
    test_round_robin();
    test_out_of_range();
    test_clear_after_grant();
    test_random();
    test_stall();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_tcdm_responder.md
Name: aes_tcdm_responder

Overview:
Memory-side TCDM responder: the slave end of the protocol the AES HWPE streamers initiate (req/gnt/add/wen/be/data, then r_valid/r_data).
- Arbitrates NB_PORTS initiator ports onto one single-bank word memory.
- Provides a backdoor port for preload and readback.
- Used in the hwpe-tb cluster stand-in to hold plaintext, ciphertext and results, with optional pseudo-random grant stalls to stress the AES FSM handshakes.

Parameters:
NB_PORTS, 4, number of TCDM initiator ports (1..8)
MEM_WORDS, 4096, memory depth in 32-bit words (power of two)
BASE_ADDR, 32'h1C01_0000, byte address of word 0
STALL_EN, 0, 1 enables LFSR-driven grant suppression
LFSR_SEED, 16'hACE1, reset/clear value of the 16-bit stall LFSR

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous soft clear
tcdm_req_i  in  NB_PORTS  request per port
tcdm_gnt_o  out  NB_PORTS  grant per port (combinational, same cycle as req)
tcdm_add_i  in  NB_PORTS x 32  byte address
tcdm_wen_i  in  NB_PORTS  1 = read, 0 = write
tcdm_be_i  in  NB_PORTS x 4  byte enables (writes only)
tcdm_data_i  in  NB_PORTS x 32  write data
tcdm_r_data_o  out  NB_PORTS x 32  response data
tcdm_r_valid_o  out  NB_PORTS  response valid, one cycle
bd_en_i  in  1  backdoor access
bd_we_i  in  1  backdoor write (1) / read (0)
bd_widx_i  in  $clog2(MEM_WORDS)  backdoor word index
bd_wdata_i  in  32  backdoor write data, full word
bd_rdata_o  out  32  backdoor read data, valid the cycle after bd_en_i
err_o  out  1  sticky out-of-range flag
err_addr_o  out  32  address of the first out-of-range access

Behaviour:
- Reset values: tcdm_gnt_o=0 (while reset_n low), tcdm_r_valid_o=0, tcdm_r_data_o=0, bd_rdata_o=0, err_o=0, err_addr_o=0, rr pointer=0, LFSR=LFSR_SEED. Memory is not reset.
- Grant, per cycle:
  - At most one port is granted.
  - Round-robin: search starts at port (last_granted+1) mod NB_PORTS; the pointer updates only on a grant.
  - gnt is a pure function of req, the pointer, the stall bit and bd_en_i.
  - No grant when bd_en_i=1 (backdoor has priority).
  - No grant when STALL_EN=1 and LFSR[0]=1.
  - LFSR: Fibonacci, taps 16,14,13,11; advances every cycle.
- Granted write (wen=0): bytes with be[i]=1 are updated at the clock edge. The response is r_valid=1 the next cycle with r_data=0.
- Granted read (wen=1): the response is r_valid=1 the next cycle with r_data = memory word. Fixed latency 1.
- r_valid is asserted only on the port granted in the previous cycle; all other ports drive r_valid=0 and r_data=0.
- Addressing: word index = (add - BASE_ADDR) >> 2; add[1:0] is ignored.
- Out of range (add < BASE_ADDR or index >= MEM_WORDS):
  - The memory is not modified.
  - A read returns 32'hDEAD_BEEF; r_valid still fires.
  - err_o is set; err_addr_o is captured only when err_o was 0.
- Write then read of the same word in consecutive cycles returns the new data. A same-cycle conflict is impossible because of the single grant.
- Ungranted request: the initiator holds req/add/data. The responder keeps no state for it.
- Backdoor:
  - bd_we_i=1 writes all 4 bytes.
  - A read returns bd_rdata_o next cycle.
  - Backdoor and port access never coincide.
- clear: rr pointer=0, LFSR=seed, err_o=0, err_addr_o=0, the pending r_valid is dropped. Memory is kept. No grant in the clear cycle.
- Reset mid-transaction: the pending response is lost; the initiator is reset with it.

Decomposition:
- Package aes_tcdm_package:
  - TCDM_POISON=32'hDEAD_BEEF.
  - LFSR tap constant.
  - Typedefs tcdm_req_t (add, wen, be, data) and tcdm_rsp_t (r_data, r_valid).
- Sub-module aes_tcdm_rr_arbiter (parameter NB_PORTS): req vector + enable in, one-hot gnt + index out, owns the pointer.

Test Plan:
- Backdoor write word 0 = 32'h0011_2233; port0 read 0x1C01_0000 -> gnt same cycle, next cycle r_valid[0]=1, r_data=32'h0011_2233.
- Port1 write 0x1C01_0004, be=4'b0101, data=32'hAABB_CCDD, over 32'hFFFF_FFFF -> backdoor read idx 1 = 32'hFFBB_FFDD; r_valid[1] pulses with r_data=0.
- All 4 ports req continuously for 8 cycles (STALL_EN=0) -> grant order 0,1,2,3,0,1,2,3; exactly one gnt per cycle; r_valid follows one cycle later on the same port.
- Port2 read 0x1C00_FFFC -> r_data=32'hDEAD_BEEF, err_o=1, err_addr_o=32'h1C00_FFFC. A later out-of-range access to 0x1C02_0000 leaves err_addr_o unchanged. clear -> err_o=0.
- STALL_EN=1, port0 holds req: grants occur only on cycles with LFSR[0]=0, checked against a reference LFSR. Each held request is served exactly once.
- Assert clear the cycle after a grant -> r_valid stays 0 and the rr pointer is 0. Then reset_n low mid-burst -> all outputs return to reset values asynchronously.
